// File: rtl/instr_feeder.sv
// ---------------------------------------------------------------------------
// instr_feeder
//
// Purpose: small program store plus sequencer that feeds instructions to a
// multi-cycle processor. After Start it presents mem[PC] on DIN with a
// one-cycle Run strobe (ISSUE). It then waits in BUSY for the processor's
// Done strobe. While in BUSY, DIN shows the word after the instruction, which
// is the immediate of an mvi (opcode 3'b001). After an mvi completes, PC
// skips that immediate. Opcode 3'b111 (HALT) is never issued; the sequencer
// parks in HALTED when it finds one.
//
// Ports:
//   Clock            single clock, rising edge
//   Resetn           asynchronous active-low reset (program store untouched)
//   Start            run from address 0 (IDLE/HALTED only)
//   Done             processor end-of-instruction strobe (sampled in BUSY)
//   WrEn/WrAddr/WrData  program-store write port (IDLE/HALTED only)
//   DIN              word presented to the processor data input
//   Run              instruction-valid strobe, high for one cycle per issue
//   PC               current program counter
//   Busy/Halted/Error   status
//
// Optional build macro: INSTR_FEEDER_WATCHDOG_EN
//   When defined, a 4-bit watchdog counts BUSY cycles without Done. On
//   reaching 15 it forces HALTED with a sticky Error. Error clears on reset or
//   on Start. When the macro is undefined, BUSY waits forever and Error is 0.
// ---------------------------------------------------------------------------
module instr_feeder #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 9
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Done,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted,
    output logic              Error
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam logic [2:0]  OP_MVI  = 3'b001;
    localparam logic [2:0]  OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_HALTED
    } state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        opc_q, opc_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic [ADDR_W-1:0] next_pc;
    logic              can_load;

`ifdef INSTR_FEEDER_WATCHDOG_EN
    logic [3:0]        wd_q, wd_d;
    logic              error_q, error_d;
`endif

    function automatic logic [2:0] op_of(input logic [DATA_W-1:0] w);
        return w[DATA_W-1 -: 3];
    endfunction

    assign can_load = (state_q == S_IDLE) || (state_q == S_HALTED);

    // Program store has no reset, so its contents survive Resetn.
    always_ff @(posedge Clock) begin
        if (WrEn && can_load) begin
            mem_q[WrAddr] <= WrData;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        opc_d   = opc_q;
        next_pc = pc_q;
`ifdef INSTR_FEEDER_WATCHDOG_EN
        wd_d    = wd_q;
        error_d = error_q;
`endif
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (Start) begin
                    pc_d    = '0;
                    state_d = (op_of(mem_q[0]) == OP_HALT) ? S_HALTED : S_ISSUE;
`ifdef INSTR_FEEDER_WATCHDOG_EN
                    error_d = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                opc_d   = op_of(mem_q[pc_q]);
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_BUSY;
`ifdef INSTR_FEEDER_WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            S_BUSY: begin
                if (Done) begin
                    // PC already points past the opcode. An mvi also consumes
                    // the immediate word shown on DIN during BUSY.
                    next_pc = (opc_q == OP_MVI) ? pc_q + ADDR_W'(1) : pc_q;
                    pc_d    = next_pc;
                    state_d = (op_of(mem_q[next_pc]) == OP_HALT) ? S_HALTED : S_ISSUE;
                end
`ifdef INSTR_FEEDER_WATCHDOG_EN
                else begin
                    wd_d = wd_q + 4'd1;
                    if (wd_d == 4'd15) begin
                        state_d = S_HALTED;
                        error_d = 1'b1;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered from the next state so they line up
        // with state_q without extra decode after the flops.
        run_d    = (state_d == S_ISSUE);
        busy_d   = (state_d == S_ISSUE) || (state_d == S_BUSY);
        halted_d = (state_d == S_HALTED);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            opc_q    <= '0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
`ifdef INSTR_FEEDER_WATCHDOG_EN
            wd_q     <= '0;
            error_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            opc_q    <= opc_d;
            run_q    <= run_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
`ifdef INSTR_FEEDER_WATCHDOG_EN
            wd_q     <= wd_d;
            error_q  <= error_d;
`endif
        end
    end

    assign DIN    = busy_q ? mem_q[pc_q] : '0;
    assign Run    = run_q;
    assign PC     = pc_q;
    assign Busy   = busy_q;
    assign Halted = halted_q;
`ifdef INSTR_FEEDER_WATCHDOG_EN
    assign Error  = error_q;
`else
    assign Error  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_feeder.sv
// ---------------------------------------------------------------------------
// tb_instr_feeder
//
// Directed bench for instr_feeder (ADDR_W=4, DATA_W=9). A vector table
// drives the mvi/mv/HALT program cycle by cycle. Hand-written sequences then
// cover the multi-cycle cases: delayed Done, HALT at address 0, rejected
// writes while busy, asynchronous reset mid-instruction, PC wrap-around and
// the optional watchdog.
// ---------------------------------------------------------------------------
module tb_instr_feeder;

    logic       Clock;
    logic       Resetn;
    logic       Start;
    logic       Done;
    logic       WrEn;
    logic [3:0] WrAddr;
    logic [8:0] WrData;
    logic [8:0] DIN;
    logic       Run;
    logic [3:0] PC;
    logic       Busy;
    logic       Halted;
    logic       Error;

    int unsigned n_checks;
    int unsigned n_fail;

    instr_feeder #(
        .ADDR_W(4),
        .DATA_W(9)
    ) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .Start (Start),
        .Done  (Done),
        .WrEn  (WrEn),
        .WrAddr(WrAddr),
        .WrData(WrData),
        .DIN   (DIN),
        .Run   (Run),
        .PC    (PC),
        .Busy  (Busy),
        .Halted(Halted),
        .Error (Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic       start;
        logic       done;
        logic       run;
        logic [8:0] din;
        logic [3:0] pc;
        logic       busy;
        logic       halted;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic s, input logic d, input logic r,
                                input logic [8:0] din, input logic [3:0] pc,
                                input logic b, input logic h);
        vec_t v;
        v.start = s; v.done = d; v.run = r; v.din = din;
        v.pc = pc; v.busy = b; v.halted = h;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [8:0] d);
        WrEn = 1'b1; WrAddr = a; WrData = d;
        tick();
        WrEn = 1'b0;
    endtask

    // Pull Resetn low between edges and check the immediate effect.
    task automatic async_reset(input string tag);
        #2 Resetn = 1'b0;
        #1;
        chk({tag, "_rst_run"},    32'(Run),    32'd0);
        chk({tag, "_rst_din"},    32'(DIN),    32'd0);
        chk({tag, "_rst_pc"},     32'(PC),     32'd0);
        chk({tag, "_rst_busy"},   32'(Busy),   32'd0);
        chk({tag, "_rst_halted"}, 32'(Halted), 32'd0);
        chk({tag, "_rst_error"},  32'(Error),  32'd0);
        #1 Resetn = 1'b1;
    endtask

    initial begin
        int unsigned nb;
        int unsigned nr;
        n_checks = 0;
        n_fail   = 0;
        Resetn = 1'b1; Start = 1'b0; Done = 1'b0;
        WrEn = 1'b0; WrAddr = '0; WrData = '0;

        // Program {040,005,008,1C0}: mvi R0,#5 ; mv R1,R0 ; HALT
        vecs[0]  = mk(1'b1, 1'b0, 1'b1, 9'h040, 4'd0, 1'b1, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 9'h005, 4'd1, 1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b1, 9'h008, 4'd2, 1'b1, 1'b0);
        vecs[3]  = mk(1'b0, 1'b0, 1'b0, 9'h1C0, 4'd3, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 9'h000, 4'd3, 1'b0, 1'b1);
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 9'h000, 4'd3, 1'b0, 1'b1); // Done in HALTED ignored
        vecs[6]  = mk(1'b1, 1'b0, 1'b1, 9'h040, 4'd0, 1'b1, 1'b0); // restart from HALTED
        vecs[7]  = mk(1'b1, 1'b0, 1'b0, 9'h005, 4'd1, 1'b1, 1'b0); // Start in ISSUE ignored
        vecs[8]  = mk(1'b1, 1'b0, 1'b0, 9'h005, 4'd1, 1'b1, 1'b0); // Start in BUSY ignored
        vecs[9]  = mk(1'b0, 1'b1, 1'b1, 9'h008, 4'd2, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 9'h1C0, 4'd3, 1'b1, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 1'b0, 9'h000, 4'd3, 1'b0, 1'b1);

        // Reset state
        #2 Resetn = 1'b0;
        #1;
        chk("reset_run",    32'(Run),    32'd0);
        chk("reset_din",    32'(DIN),    32'd0);
        chk("reset_pc",     32'(PC),     32'd0);
        chk("reset_busy",   32'(Busy),   32'd0);
        chk("reset_halted", 32'(Halted), 32'd0);
        chk("reset_error",  32'(Error),  32'd0);
        #9 Resetn = 1'b1;

        wr(4'd0, 9'h040);
        wr(4'd1, 9'h005);
        wr(4'd2, 9'h008);
        wr(4'd3, 9'h1C0);
        chk("idle_busy", 32'(Busy), 32'd0);

        for (int unsigned i = 0; i < 12; i++) begin
            Start = vecs[i].start;
            Done  = vecs[i].done;
            tick();
            chk($sformatf("v%0d_run", i),    32'(Run),    32'(vecs[i].run));
            chk($sformatf("v%0d_din", i),    32'(DIN),    32'(vecs[i].din));
            chk($sformatf("v%0d_pc", i),     32'(PC),     32'(vecs[i].pc));
            chk($sformatf("v%0d_busy", i),   32'(Busy),   32'(vecs[i].busy));
            chk($sformatf("v%0d_halted", i), 32'(Halted), 32'(vecs[i].halted));
        end
        Start = 1'b0; Done = 1'b0;

        // HALT at address 0: straight to HALTED, no Run
        wr(4'd0, 9'h1C0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("halt0_halted", 32'(Halted), 32'd1);
        chk("halt0_run",    32'(Run),    32'd0);
        chk("halt0_pc",     32'(PC),     32'd0);
        chk("halt0_busy",   32'(Busy),   32'd0);
        tick();
        chk("halt0_run2",   32'(Run),    32'd0);

        // Delayed Done: Done arrives in the fourth BUSY cycle.
        // 050 carries opcode 001, so PC steps over word 1 and finds HALT at 2.
        wr(4'd0, 9'h050);
        wr(4'd1, 9'h1C0);
        wr(4'd2, 9'h1C0);
        nb = 0; nr = 0;
        Start = 1'b1;
        for (int unsigned i = 0; i < 12; i++) begin
            tick();
            Start = 1'b0;
            if (Busy) nb++;
            if (Run)  nr++;
            if (i == 0) chk("dly_run_issue", 32'(Run), 32'd1);
            else        chk($sformatf("dly_run_low%0d", i), 32'(Run), 32'd0);
            Done = (Busy && nb == 5);
        end
        Done = 1'b0;
        chk("dly_busy_cycles", nb, 32'd5);
        chk("dly_run_pulses",  nr, 32'd1);
        chk("dly_halted",      32'(Halted), 32'd1);
        chk("dly_pc",          32'(PC),     32'd2);

        // Writes while ISSUE/BUSY are dropped: word 2 stays HALT
        Start = 1'b1;
        tick();
        Start = 1'b0;
        WrEn = 1'b1; WrAddr = 4'd2; WrData = 9'h008;
        tick();
        tick();
        Done = 1'b1;
        tick();
        WrEn = 1'b0; Done = 1'b0;
        chk("wrbusy_halted", 32'(Halted), 32'd1);
        chk("wrbusy_pc",     32'(PC),     32'd2);

        // Same write in HALTED is accepted and used on the next run
        wr(4'd2, 9'h008);
        wr(4'd3, 9'h1C0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        Done = 1'b1;
        tick();
        Done = 1'b0;
        chk("wrhalt_run", 32'(Run), 32'd1);
        chk("wrhalt_pc",  32'(PC),  32'd2);
        chk("wrhalt_din", 32'(DIN), 32'h008);
        tick();
        chk("wrhalt_busy", 32'(Busy), 32'd1);
        async_reset("midbusy");
        tick();
        chk("postrst_busy", 32'(Busy), 32'd0);
        // Store survives reset
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("keep_din", 32'(DIN), 32'h050);
        chk("keep_run", 32'(Run), 32'd1);
        async_reset("keep");

        // PC wrap: sixteen mv words, no HALT anywhere
        for (int unsigned a = 0; a < 16; a++) wr(4'(a), 9'h008);
        Done  = 1'b1;
        Start = 1'b1;
        for (int unsigned k = 0; k <= 16; k++) begin
            tick();
            Start = 1'b0;
            chk($sformatf("wrap_run_i%0d", k), 32'(Run), 32'd1);
            chk($sformatf("wrap_pc_i%0d", k),  32'(PC),  32'(4'(k % 16)));
            tick();
            chk($sformatf("wrap_run_b%0d", k), 32'(Run), 32'd0);
            chk($sformatf("wrap_pc_b%0d", k),  32'(PC),  32'(4'((k + 1) % 16)));
        end
        Done = 1'b0;
        async_reset("wrap");

        // Done withheld
        wr(4'd0, 9'h050);
        wr(4'd1, 9'h1C0);
        wr(4'd2, 9'h1C0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("wd_issue_run", 32'(Run), 32'd1);
`ifdef INSTR_FEEDER_WATCHDOG_EN
        for (int unsigned i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("wd_busy%0d", i),   32'(Busy),   32'd1);
            chk($sformatf("wd_halted%0d", i), 32'(Halted), 32'd0);
        end
        tick();
        chk("wd_trip_halted", 32'(Halted), 32'd1);
        chk("wd_trip_error",  32'(Error),  32'd1);
        chk("wd_trip_busy",   32'(Busy),   32'd0);
        tick();
        chk("wd_sticky_error", 32'(Error), 32'd1);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("wd_clr_error", 32'(Error), 32'd0);
        chk("wd_clr_busy",  32'(Busy),  32'd1);
`else
        for (int unsigned i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("hold_busy%0d", i),  32'(Busy),  32'd1);
            chk($sformatf("hold_error%0d", i), 32'(Error), 32'd0);
        end
`endif
        async_reset("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
